// File: rtl/sprite_blitter_pkg.sv
// Shared types and widths for the sprite blitter: FSM states, screen defaults,
// coordinate and ROM address widths.
package sprite_blitter_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int X_W          = 8;
    localparam int Y_W          = 7;
    localparam int ADDR_W       = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Raster-order column/row/address counters for the sprite ROM walk.
// The address is advanced incrementally so no multiplier is needed.
module sprite_addr_gen
    import sprite_blitter_pkg::*;
#(
    parameter int SPR_W = SCREEN_W_DEF,
    parameter int SPR_H = SCREEN_H_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              i_clear,
    input  logic              i_step,
    output logic [X_W-1:0]    o_col,
    output logic [Y_W-1:0]    o_row,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [X_W-1:0]    r_col;
    logic [Y_W-1:0]    r_row;
    logic [ADDR_W-1:0] r_addr;
    logic              w_col_end;

    assign w_col_end = (r_col == X_W'(SPR_W - 1));
    assign o_last    = w_col_end && (r_row == Y_W'(SPR_H - 1));
    assign o_col     = r_col;
    assign o_row     = r_row;
    assign o_addr    = r_addr;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (i_clear) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (i_step) begin
            r_addr <= r_addr + 1'b1;
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Copies a sprite from ROM to the vga_adapter pixel port at one pixel per cycle,
// with clipping, optional transparency key and abort.
module sprite_blitter
    import sprite_blitter_pkg::*;
#(
    parameter int              SCREEN_W   = SCREEN_W_DEF,
    parameter int              SCREEN_H   = SCREEN_H_DEF,
    parameter int              SPR_W      = SCREEN_W_DEF,
    parameter int              SPR_H      = SCREEN_H_DEF,
    parameter int              PIX_W      = 1,
    parameter int              ROM_LAT    = 1,
    parameter logic [2:0]      FG_COLOUR  = 3'b000,
    parameter logic [2:0]      BG_COLOUR  = 3'b010,
    parameter bit              TRANSP_EN  = 1'b0,
    parameter logic [PIX_W-1:0] TRANSP_KEY = '0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [X_W-1:0]    x0,
    input  logic [Y_W-1:0]    y0,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_q,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [2:0]        colour,
    output logic              plot,
    output logic              busy,
    output logic              done
);

    localparam logic [X_W:0] SCR_W_L = SCREEN_W[X_W:0];
    localparam logic [Y_W:0] SCR_H_L = SCREEN_H[Y_W:0];

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [2:0]        r_drain;
    logic [X_W-1:0]    r_x0;
    logic [Y_W-1:0]    r_y0;
    logic [ROM_LAT:0]  r_vld_pipe;
    logic [X_W-1:0]    r_col_d [1:ROM_LAT];
    logic [Y_W-1:0]    r_row_d [1:ROM_LAT];
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [2:0]        r_colour;
    logic              r_plot;

    logic [X_W-1:0]    w_col;
    logic [Y_W-1:0]    w_row;
    logic              w_last;
    logic              w_accept;
    logic              w_step;
    logic              w_flush;
    logic [X_W:0]      w_x_sum;
    logic [Y_W:0]      w_y_sum;
    logic              w_transp;
    logic [2:0]        w_colour;

    assign w_accept = (r_state == ST_IDLE) && start && !abort;
    assign w_step   = (r_state == ST_SCAN) && !abort && !w_last;
    assign w_flush  = abort && ((r_state == ST_SCAN) || (r_state == ST_DRAIN));

    sprite_addr_gen #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_addr_gen (
        .clock   (clock),
        .resetn  (resetn),
        .i_clear (w_accept),
        .i_step  (w_step),
        .o_col   (w_col),
        .o_row   (w_row),
        .o_addr  (rom_addr),
        .o_last  (w_last)
    );

    // r_vld_pipe[0] marks rom_addr as a live request; bit k follows it k cycles later.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_drain    <= '0;
            r_x0       <= '0;
            r_y0       <= '0;
            r_vld_pipe <= '0;
        end else begin
            r_done                <= 1'b0;
            r_vld_pipe[ROM_LAT:1] <= r_vld_pipe[ROM_LAT-1:0];
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state       <= ST_SCAN;
                        r_busy        <= 1'b1;
                        r_vld_pipe[0] <= 1'b1;
                        r_x0          <= x0;
                        r_y0          <= y0;
                    end
                end
                ST_SCAN: begin
                    if (abort) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_vld_pipe <= '0;
                    end else if (w_last) begin
                        r_state       <= ST_DRAIN;
                        r_vld_pipe[0] <= 1'b0;
                        r_drain       <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_vld_pipe <= '0;
                    end else if (r_drain == 3'(ROM_LAT)) begin
                        r_state <= ST_FINISH;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                ST_FINISH: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 1; i <= ROM_LAT; i++) begin
                r_col_d[i] <= '0;
                r_row_d[i] <= '0;
            end
        end else begin
            r_col_d[1] <= w_col;
            r_row_d[1] <= w_row;
            for (int i = 2; i <= ROM_LAT; i++) begin
                r_col_d[i] <= r_col_d[i-1];
                r_row_d[i] <= r_row_d[i-1];
            end
        end
    end

    // Sums are one bit wider so off-screen pixels clip instead of wrapping.
    assign w_x_sum  = {1'b0, r_x0} + {1'b0, r_col_d[ROM_LAT]};
    assign w_y_sum  = {1'b0, r_y0} + {1'b0, r_row_d[ROM_LAT]};
    assign w_transp = TRANSP_EN && (rom_q == TRANSP_KEY);

    if (PIX_W == 1) begin : g_mono
        assign w_colour = rom_q[0] ? FG_COLOUR : BG_COLOUR;
    end else begin : g_rgb
        assign w_colour = rom_q[2:0];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= 3'b000;
            r_plot   <= 1'b0;
        end else if (w_flush) begin
            r_plot <= 1'b0;
        end else begin
            r_plot <= r_vld_pipe[ROM_LAT] && (w_x_sum < SCR_W_L) &&
                      (w_y_sum < SCR_H_L) && !w_transp;
            if (r_vld_pipe[ROM_LAT]) begin
                r_x      <= w_x_sum[X_W-1:0];
                r_y      <= w_y_sum[Y_W-1:0];
                r_colour <= w_colour;
            end
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: 4x3 sprite, ROM latency 1, one plain
// instance (A) and one with transparency keyed on 0 (B).
module tb_sprite_blitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, abort_a, start_b, abort_b;
    logic [7:0]  x0_a, x0_b, x_a, x_b;
    logic [6:0]  y0_a, y0_b, y_a, y_b;
    logic [14:0] addr_a, addr_b;
    logic [0:0]  q_a, q_b;
    logic [2:0]  col_a, col_b;
    logic        plot_a, plot_b, busy_a, busy_b, done_a, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sprite_blitter #(.SPR_W(4), .SPR_H(3), .ROM_LAT(1), .PIX_W(1)) dut_a (
        .clock(clk), .resetn(rst_n), .start(start_a), .abort(abort_a),
        .x0(x0_a), .y0(y0_a), .rom_addr(addr_a), .rom_q(q_a),
        .x(x_a), .y(y_a), .colour(col_a), .plot(plot_a), .busy(busy_a), .done(done_a));

    sprite_blitter #(.SPR_W(4), .SPR_H(3), .ROM_LAT(1), .PIX_W(1),
                     .TRANSP_EN(1'b1), .TRANSP_KEY(1'b0)) dut_b (
        .clock(clk), .resetn(rst_n), .start(start_b), .abort(abort_b),
        .x0(x0_b), .y0(y0_b), .rom_addr(addr_b), .rom_q(q_b),
        .x(x_b), .y(y_b), .colour(col_b), .plot(plot_b), .busy(busy_b), .done(done_b));

    // One-cycle ROMs: A holds 1 at every third address, B alternates 1/0.
    always @(posedge clk) begin
        q_a <= (addr_a % 15'd3 == 15'd0) ? 1'b1 : 1'b0;
        q_b <= ~addr_b[0:0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int p;
        rst_n = 1'b0;
        start_a = 0; abort_a = 0; x0_a = 0; y0_a = 0;
        start_b = 0; abort_b = 0; x0_b = 0; y0_b = 0;
        tick(); tick();
        chk("rst busy", busy_a, 0);
        chk("rst done", done_a, 0);
        chk("rst plot", plot_a, 0);
        chk("rst addr", addr_a, 0);
        chk("rst colour", col_a, 0);
        rst_n = 1'b1;
        tick();

        // Basic 4x3 blit at (10,5): start sampled at edge 0
        x0_a = 8'd10; y0_a = 7'd5; start_a = 1;
        tick();
        start_a = 0;
        chk("s35 e0 addr", addr_a, 0);
        chk("s35 e0 busy", busy_a, 1);
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (e <= 11) chk($sformatf("s35 e%0d addr", e), addr_a, e);
            chk($sformatf("s35 e%0d plot", e), plot_a, (e >= 2 && e <= 13));
            if (e >= 2 && e <= 13) begin
                p = e - 2;
                chk($sformatf("s35 e%0d x", e), x_a, 10 + p % 4);
                chk($sformatf("s35 e%0d y", e), y_a, 5 + p / 4);
                chk($sformatf("s35 e%0d colour", e), col_a, (p % 3 == 0) ? 0 : 2);
            end
            chk($sformatf("s35 e%0d done", e), done_a, (e == 14));
            chk($sformatf("s35 e%0d busy", e), busy_a, (e < 14));
        end

        // Back-to-back start at the corner; extra start pulses while busy are ignored
        x0_a = 8'd158; y0_a = 7'd119; start_a = 1;
        tick();
        start_a = 0;
        chk("b2b addr", addr_a, 0);
        chk("b2b busy", busy_a, 1);
        for (int e = 1; e <= 15; e++) begin
            start_a = (e >= 3 && e <= 5);
            tick();
            if (e <= 11) chk($sformatf("s36 e%0d addr", e), addr_a, e);
            chk($sformatf("s36 e%0d plot", e), plot_a, (e == 2 || e == 3));
            if (e == 2 || e == 3) begin
                chk($sformatf("s36 e%0d x", e), x_a, 156 + e);
                chk($sformatf("s36 e%0d y", e), y_a, 119);
            end
            chk($sformatf("s36 e%0d done", e), done_a, (e == 14));
        end
        start_a = 0;
        for (int e = 16; e <= 20; e++) begin
            tick();
            chk($sformatf("s36 e%0d idle busy", e), busy_a, 0);
            chk($sformatf("s36 e%0d idle done", e), done_a, 0);
        end

        // Abort sampled at edge 6, restart at edge 7
        x0_a = 8'd10; y0_a = 7'd5; start_a = 1;
        tick();
        start_a = 0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk($sformatf("s38 e%0d addr", e), addr_a, e);
        end
        abort_a = 1;
        tick();
        abort_a = 0;
        chk("s38 e6 plot", plot_a, 0);
        chk("s38 e6 busy", busy_a, 0);
        chk("s38 e6 done", done_a, 0);
        start_a = 1;
        tick();
        start_a = 0;
        chk("s38 e7 addr", addr_a, 0);
        chk("s38 e7 busy", busy_a, 1);
        chk("s38 e7 plot", plot_a, 0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("s38 r%0d plot", k), plot_a, (k >= 2 && k <= 13));
            chk($sformatf("s38 r%0d done", k), done_a, (k == 14));
        end

        // Abort together with start in IDLE drops the start
        abort_a = 1; start_a = 1;
        tick();
        abort_a = 0; start_a = 0;
        chk("abort+start busy", busy_a, 0);
        tick();
        chk("abort+start busy2", busy_a, 0);
        chk("abort+start plot", plot_a, 0);

        // Transparency: only the 1 pixels (even indices) are plotted
        x0_b = 8'd0; y0_b = 7'd0; start_b = 1;
        tick();
        start_b = 0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            p = e - 2;
            chk($sformatf("s37 e%0d plot", e), plot_b, (e >= 2 && e <= 13 && p % 2 == 0));
            if (e >= 2 && e <= 13 && p % 2 == 0) begin
                chk($sformatf("s37 e%0d colour", e), col_b, 0);
                chk($sformatf("s37 e%0d x", e), x_b, p % 4);
                chk($sformatf("s37 e%0d y", e), y_b, p / 4);
            end
            chk($sformatf("s37 e%0d done", e), done_b, (e == 14));
        end

        // Asynchronous reset mid-SCAN
        x0_a = 8'd10; y0_a = 7'd5; start_a = 1;
        tick();
        start_a = 0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("s39 async busy", busy_a, 0);
        chk("s39 async done", done_a, 0);
        chk("s39 async plot", plot_a, 0);
        chk("s39 async x", x_a, 0);
        chk("s39 async y", y_a, 0);
        chk("s39 async colour", col_a, 0);
        chk("s39 async addr", addr_a, 0);
        tick();
        rst_n = 1'b1;
        for (int e = 0; e < 16; e++) begin
            tick();
            chk($sformatf("s39 post%0d plot", e), plot_a, 0);
            chk($sformatf("s39 post%0d done", e), done_a, 0);
            chk($sformatf("s39 post%0d busy", e), busy_a, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameter SCREEN_W, default 160, frame width in pixels.
REQ-002 Parameter SCREEN_H, default 120, frame height in pixels.
REQ-003 Parameter SPR_W, default 160, sprite width; range 1..SCREEN_W.
REQ-004 Parameter SPR_H, default 120, sprite height; range 1..SCREEN_H.
REQ-005 Parameter PIX_W, default 1, ROM pixel width; legal values are 1 (mono) and 3 (RGB).
REQ-006 Parameter ROM_LAT, default 1, ROM read latency in cycles; range 1..4.
REQ-007 Parameters FG_COLOUR (3'b000) and BG_COLOUR (3'b010) set the mono-mode colour map.
REQ-008 Parameters TRANSP_EN (0) and TRANSP_KEY (0, PIX_W bits) set the transparency key.
REQ-009 Port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-010 Port resetn, input, 1: asynchronous, active-low reset.
REQ-011 Port start, input, 1: request one blit; sampled only in IDLE.
REQ-012 Port abort, input, 1: cancel the blit in progress.
REQ-013 Ports x0 and y0, inputs, 8 and 7 bits: sprite origin; captured when start is accepted.
REQ-014 Port rom_addr, output, 15 bits: registered sprite ROM address.
REQ-015 Port rom_q, input, PIX_W bits: ROM data, valid ROM_LAT cycles after rom_addr.
REQ-016 Ports x and y, outputs, 8 and 7 bits: screen coordinate for the vga_adapter.
REQ-017 Ports colour (output, 3 bits) and plot (output, 1 bit): pixel write to the vga_adapter.
REQ-018 Ports busy and done, outputs, 1 bit each: busy is high from acceptance until done; done is a one-cycle pulse.

Function
REQ-019 FSM states: IDLE, SCAN, DRAIN, FINISH.
- IDLE->SCAN on start.
- SCAN->DRAIN after the last address is issued.
- DRAIN->FINISH after ROM_LAT+1 cycles.
- FINISH->IDLE unconditionally.
REQ-020 start acceptance: start=1 in IDLE at edge k captures x0/y0, sets busy at k, and issues rom_addr=0 at k.
REQ-021 SCAN issues one address per cycle in raster order: col 0..SPR_W-1, then row+1; rom_addr = row*SPR_W+col, generated incrementally with no multiplier.
REQ-022 (col,row) and a valid bit travel through a ROM_LAT-deep delay line aligned with rom_q.
REQ-023 The output stage registers x=x0+col and y=y0+row, with sums one bit wider than the ports, one cycle after rom_q is valid.
- The pixel whose address was issued at edge n appears on the outputs at edge n+ROM_LAT+1.
REQ-024 Colour mapping:
- PIX_W=1: colour = rom_q ? FG_COLOUR : BG_COLOUR.
- PIX_W=3: colour = rom_q.
REQ-025 plot = valid AND x<SCREEN_W AND y<SCREEN_H AND NOT(TRANSP_EN AND rom_q==TRANSP_KEY).
- Clipped and transparent pixels still consume their cycle.
REQ-026 done pulses in FINISH, one cycle after the last pixel's output cycle; busy falls at the same edge.
REQ-027 start while busy is ignored, with no queuing.
REQ-028 abort while busy:
- next state is IDLE;
- the pipeline valid bits are flushed, so plot=0 from the next edge;
- done is not pulsed.
REQ-029 abort and start asserted together in IDLE: abort wins and the start is dropped.
REQ-030 Back-to-back: start asserted in the cycle after FINISH is accepted normally.

Reset
REQ-031 resetn=0 asynchronously forces:
- state=IDLE; busy=0; done=0; plot=0;
- x=0; y=0; colour=3'b000; rom_addr=0;
- all pipeline valid bits to 0.
REQ-032 Reset mid-blit abandons the blit; no plot or done is produced after release until a new start.

Structure
REQ-033 The shared package holds:
- the FSM state enumeration;
- the 160x120 defaults;
- the coordinate widths (8/7) and ROM address width (15).
REQ-034 Sub-module sprite_addr_gen holds the col/row/address counters and their last-pixel flag; the FSM, delay line and output stage stay in sprite_blitter.

Verification
REQ-035 Scenario: SPR_W=4, SPR_H=3, ROM_LAT=1, x0=10, y0=5, start at edge 0.
- rom_addr runs 0..11 on edges 0..11.
- plot is high on edges 2..13 with (x,y) from (10,5) to (13,7).
- done pulses at edge 14.
REQ-036 Scenario: x0=158, y0=119, 4x3 sprite.
- plot is high only for (158,119) and (159,119).
- done still pulses 14 edges after start.
REQ-037 Scenario: PIX_W=1, TRANSP_EN=1, TRANSP_KEY=0, alternating ROM 1/0.
- plot is high on every other pixel, with colour=3'b000 on those pixels.
REQ-038 Scenario: abort at edge 5 of a 4x3 blit.
- plot=0 from edge 6 onward.
- No done pulse; busy=0 at edge 6.
- A new start at edge 7 restarts at rom_addr=0.
REQ-039 Scenario: resetn low for 1 cycle mid-SCAN.
- All outputs take REQ-031 values immediately, without waiting for a clock edge.
- start pulses during busy (repeat run) produce no second blit.
